// File: rtl/lsu_stage_pkg.sv
// Shared types and encodings for the load/store stage: mem_op codes, FSM states
// and the natural-alignment rule used by the lane aligner.
package lsu_stage_pkg;

  localparam int Xlen       = 64;
  localparam int MemOpWidth = 4;
  localparam int RdWidth    = 5;

  // mem_op = {store, zeroExt, log2 bytes}
  localparam logic [MemOpWidth-1:0] MemLb  = 4'b0000;
  localparam logic [MemOpWidth-1:0] MemLh  = 4'b0001;
  localparam logic [MemOpWidth-1:0] MemLw  = 4'b0010;
  localparam logic [MemOpWidth-1:0] MemLd  = 4'b0011;
  localparam logic [MemOpWidth-1:0] MemLbu = 4'b0100;
  localparam logic [MemOpWidth-1:0] MemLhu = 4'b0101;
  localparam logic [MemOpWidth-1:0] MemLwu = 4'b0110;
  localparam logic [MemOpWidth-1:0] MemSb  = 4'b1000;
  localparam logic [MemOpWidth-1:0] MemSh  = 4'b1001;
  localparam logic [MemOpWidth-1:0] MemSw  = 4'b1010;
  localparam logic [MemOpWidth-1:0] MemSd  = 4'b1011;

  typedef enum logic [1:0] {
    LsuIdle = 2'd0,
    LsuReq  = 2'd1,
    LsuResp = 2'd2,
    LsuOut  = 2'd3
  } lsuStateT;

  function automatic logic isMisaligned(input logic [2:0] addrLow, input logic [1:0] size);
    case (size)
      2'd1:    return addrLow[0];
      2'd2:    return |addrLow[1:0];
      2'd3:    return |addrLow;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store data/mask placement, alignment check and
// load extraction with sign or zero extension.
module lsu_align
  import lsu_stage_pkg::*;
(
  input  logic [2:0]      addrLow,
  input  logic [1:0]      size,
  input  logic            zeroExt,
  input  logic [Xlen-1:0] storeData,
  input  logic [Xlen-1:0] rdata,
  output logic [Xlen-1:0] wdata,
  output logic [7:0]      wmask,
  output logic            misalign,
  output logic [Xlen-1:0] loadData
);

  logic [5:0]      laneShift;
  logic [7:0]      sizeMask;
  logic [Xlen-1:0] shifted;

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    laneShift = {addrLow, 3'b000};
    wdata     = storeData << laneShift;
    shifted   = rdata >> laneShift;
    misalign  = isMisaligned(addrLow, size);
    sizeMask  = 8'hFF;
    loadData  = shifted;
    case (size)
      2'd0: begin
        sizeMask = 8'h01;
        loadData = {{56{~zeroExt & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        sizeMask = 8'h03;
        loadData = {{48{~zeroExt & shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        sizeMask = 8'h0F;
        loadData = {{32{~zeroExt & shifted[31]}}, shifted[31:0]};
      end
      default: begin
        sizeMask = 8'hFF;
        loadData = shifted;
      end
    endcase
    wmask = sizeMask << addrLow;
  end

endmodule

// File: rtl/lsu_stage.sv
// Single-entry memory stage: registers an EX op, issues at most one data-memory
// request, and presents the result to writeback with valid/ready handshakes.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int XLEN    = Xlen,
  parameter int MEMOP_W = MemOpWidth,
  parameter int RD_W    = RdWidth
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic [XLEN-1:0]    in_store_data,
  input  logic               in_is_mem,
  input  logic [MEMOP_W-1:0] in_mem_op,
  input  logic [RD_W-1:0]    in_rd,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_req_addr,
  output logic               mem_req_we,
  output logic [XLEN-1:0]    mem_req_wdata,
  output logic [7:0]         mem_req_wmask,
  input  logic               mem_resp_valid,
  input  logic [XLEN-1:0]    mem_resp_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RD_W-1:0]    out_rd,
  output logic               out_wen,
  output logic               out_misalign
);

  lsuStateT state, nextState;

  logic [XLEN-1:0]    addrReg, storeDataReg, resultReg;
  logic [MEMOP_W-1:0] memOpReg;
  logic [RD_W-1:0]    rdReg;
  logic               wenReg, misalignReg;

  logic               idle, accept;
  logic [2:0]         alignAddr;
  logic [MEMOP_W-1:0] alignOp;
  logic [XLEN-1:0]    alignWdata, alignLoad;
  logic [7:0]         alignWmask;
  logic               alignMisalign;

  assign idle   = (state == LsuIdle);
  assign accept = idle && in_valid;

  // While idle the aligner judges the incoming op; afterwards it works on the held op.
  assign alignAddr = idle ? in_alu_result[2:0] : addrReg[2:0];
  assign alignOp   = idle ? in_mem_op : memOpReg;

  lsu_align u_align (
    .addrLow   (alignAddr),
    .size      (alignOp[1:0]),
    .zeroExt   (alignOp[2]),
    .storeData (storeDataReg),
    .rdata     (mem_resp_rdata),
    .wdata     (alignWdata),
    .wmask     (alignWmask),
    .misalign  (alignMisalign),
    .loadData  (alignLoad)
  );

  always_comb begin
    nextState = state;
    case (state)
      LsuIdle: if (in_valid) nextState = (!in_is_mem || alignMisalign) ? LsuOut : LsuReq;
      LsuReq:  if (mem_req_ready) nextState = LsuResp;
      LsuResp: if (mem_resp_valid) nextState = LsuOut;
      LsuOut:  if (out_ready) nextState = LsuIdle;
      default: nextState = LsuIdle;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LsuIdle;
      addrReg      <= '0;
      storeDataReg <= '0;
      resultReg    <= '0;
      memOpReg     <= '0;
      rdReg        <= '0;
      wenReg       <= 1'b0;
      misalignReg  <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) begin
        addrReg      <= in_alu_result;
        storeDataReg <= in_store_data;
        memOpReg     <= in_mem_op;
        rdReg        <= in_rd;
        resultReg    <= in_is_mem ? '0 : in_alu_result;
        misalignReg  <= in_is_mem && alignMisalign;
        wenReg       <= !in_is_mem || (!in_mem_op[3] && !alignMisalign);
      end else if (state == LsuResp && mem_resp_valid && !memOpReg[3]) begin
        resultReg <= alignLoad;
      end
    end
  end

  // Outputs are gated by state so every data output reads zero when inactive.
  assign in_ready      = idle;
  assign mem_req_valid = (state == LsuReq);
  assign mem_req_addr  = mem_req_valid ? {addrReg[XLEN-1:3], 3'b000} : '0;
  assign mem_req_we    = mem_req_valid && memOpReg[3];
  assign mem_req_wdata = mem_req_valid ? alignWdata : '0;
  assign mem_req_wmask = mem_req_valid ? alignWmask : '0;

  assign out_valid    = (state == LsuOut);
  assign out_result   = out_valid ? resultReg : '0;
  assign out_rd       = out_valid ? rdReg : '0;
  assign out_wen      = out_valid && wenReg;
  assign out_misalign = out_valid && misalignReg;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: pass-through, loads, stores, misalignment,
// backpressure and reset mid-transaction against hand-computed values.
module tb_lsu_stage;
  import lsu_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [63:0] in_alu_result, in_store_data;
  logic        in_is_mem;
  logic [3:0]  in_mem_op;
  logic [4:0]  in_rd;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        out_valid, out_ready, out_wen, out_misalign;
  logic [63:0] out_result;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  int reqCount = 0;
  int base;
  int lat;

  lsu_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_is_mem      (in_is_mem),
    .in_mem_op      (in_mem_op),
    .in_rd          (in_rd),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wen        (out_wen),
    .out_misalign   (out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req_valid) reqCount++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for a single accepting edge, then scrambles the EX inputs.
  task automatic issue(input logic [63:0] alu, input logic [63:0] sdata, input logic isMem,
                       input logic [3:0] op, input logic [4:0] rd);
    in_valid      = 1'b1;
    in_alu_result = alu;
    in_store_data = sdata;
    in_is_mem     = isMem;
    in_mem_op     = op;
    in_rd         = rd;
    tick();
    in_valid      = 1'b0;
    in_alu_result = ~alu;
    in_store_data = ~sdata;
    in_mem_op     = ~op;
    in_rd         = ~rd;
  endtask

  task automatic waitOut(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_alu_result  = '0;
    in_store_data  = '0;
    in_is_mem      = 1'b0;
    in_mem_op      = '0;
    in_rd          = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = '0;
    out_ready      = 1'b1;
    repeat (2) tick();

    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_req_addr", mem_req_addr, 64'd0);
    rst_n = 1'b1;
    tick();

    // pass-through
    base = reqCount;
    issue(64'h1234, 64'h0, 1'b0, 4'h0, 5'd5);
    waitOut(lat);
    check("pt_latency", 64'(lat), 64'd1);
    check("pt_result", out_result, 64'h1234);
    check("pt_rd", 64'(out_rd), 64'd5);
    check("pt_wen", 64'(out_wen), 64'd1);
    check("pt_in_ready", 64'(in_ready), 64'd0);
    check("pt_no_req", 64'(reqCount - base), 64'd0);
    tick();
    check("pt_drained", 64'(out_valid), 64'd0);
    check("pt_ready_back", 64'(in_ready), 64'd1);

    // lb: byte 3 of 0x80000000 is 0x80
    mem_resp_rdata = 64'h0000_0000_8000_0000;
    issue(64'h8000_0003, 64'h0, 1'b1, MemLb, 5'd7);
    check("lb_req_valid", 64'(mem_req_valid), 64'd1);
    check("lb_req_addr", mem_req_addr, 64'h8000_0000);
    check("lb_req_we", 64'(mem_req_we), 64'd0);
    check("lb_req_wmask", 64'(mem_req_wmask), 64'h08);
    waitOut(lat);
    check("lb_latency", 64'(lat), 64'd3);
    check("lb_result", out_result, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_rd", 64'(out_rd), 64'd7);
    check("lb_wen", 64'(out_wen), 64'd1);
    tick();

    issue(64'h8000_0003, 64'h0, 1'b1, MemLbu, 5'd8);
    waitOut(lat);
    check("lbu_result", out_result, 64'h80);
    tick();

    // lw / lwu on upper word
    mem_resp_rdata = 64'hF000_0000_1234_5678;
    issue(64'h8000_0004, 64'h0, 1'b1, MemLw, 5'd10);
    waitOut(lat);
    check("lw_result", out_result, 64'hFFFF_FFFF_F000_0000);
    tick();
    issue(64'h8000_0004, 64'h0, 1'b1, MemLwu, 5'd11);
    waitOut(lat);
    check("lwu_result", out_result, 64'h0000_0000_F000_0000);
    tick();

    // sh at lane 6
    issue(64'h8000_0006, 64'hABCD, 1'b1, MemSh, 5'd12);
    check("sh_req_addr", mem_req_addr, 64'h8000_0000);
    check("sh_wmask", 64'(mem_req_wmask), 64'hC0);
    check("sh_wdata", mem_req_wdata, 64'hABCD_0000_0000_0000);
    check("sh_we", 64'(mem_req_we), 64'd1);
    waitOut(lat);
    check("sh_latency", 64'(lat), 64'd3);
    check("sh_out_wen", 64'(out_wen), 64'd0);
    check("sh_result", out_result, 64'd0);
    tick();

    // misaligned lw
    base = reqCount;
    issue(64'h8000_0002, 64'h0, 1'b1, MemLw, 5'd13);
    waitOut(lat);
    check("mis_latency", 64'(lat), 64'd1);
    check("mis_flag", 64'(out_misalign), 64'd1);
    check("mis_wen", 64'(out_wen), 64'd0);
    check("mis_rd", 64'(out_rd), 64'd13);
    check("mis_no_req", 64'(reqCount - base), 64'd0);
    tick();
    check("mis_drained", 64'(out_misalign), 64'd0);

    // backpressure on both sides; early mem_resp_valid must be ignored in REQ
    mem_req_ready  = 1'b0;
    mem_resp_rdata = 64'h8765_4321_0000_0000;
    issue(64'h8000_0004, 64'h0, 1'b1, MemLw, 5'd9);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", 64'(mem_req_valid), 64'd1);
      check("bp_req_addr", mem_req_addr, 64'h8000_0000);
      check("bp_req_wmask", 64'(mem_req_wmask), 64'hF0);
      check("bp_req_we", 64'(mem_req_we), 64'd0);
      check("bp_in_ready_req", 64'(in_ready), 64'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    check("bp_req_done", 64'(mem_req_valid), 64'd0);
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_result", out_result, 64'hFFFF_FFFF_8765_4321);
      check("bp_out_rd", 64'(out_rd), 64'd9);
      check("bp_in_ready_out", 64'(in_ready), 64'd0);
      tick();
    end
    check("bp_out_hold", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("bp_out_drained", 64'(out_valid), 64'd0);

    // reset while in RESP
    mem_resp_valid = 1'b0;
    issue(64'h8000_0010, 64'h0, 1'b1, MemLd, 5'd3);
    tick();
    check("rr_in_resp_req", 64'(mem_req_valid), 64'd0);
    check("rr_in_resp_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #2;
    check("rr_async_ready", 64'(in_ready), 64'd1);
    check("rr_async_out", 64'(out_valid), 64'd0);
    check("rr_async_result", out_result, 64'd0);
    tick();
    rst_n          = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (2) tick();
    check("rr_late_resp_out", 64'(out_valid), 64'd0);
    check("rr_late_resp_idle", 64'(in_ready), 64'd1);
    mem_resp_rdata = 64'h1122_3344_5566_7788;
    issue(64'h8000_0008, 64'h0, 1'b1, MemLd, 5'd4);
    waitOut(lat);
    check("rr_next_latency", 64'(lat), 64'd3);
    check("rr_next_result", out_result, 64'h1122_3344_5566_7788);
    check("rr_next_rd", 64'(out_rd), 64'd4);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
